// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - SDRAM-side responder with backpressure and fixed read latency
module sdram_responder #(
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 10,
  parameter int RD_LATENCY  = 3,
  parameter int MAX_PENDING = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdram_read_en,
  input  logic              sdram_write_en,
  input  logic [ADDR_W-1:0] address_sdram,
  input  logic [DATA_W-1:0] write_data,
  output logic              wait_request,
  output logic [DATA_W-1:0] read_data,
  output logic              datareadvalid,
  output logic [2:0]        pending_cnt,
  output logic              proto_err
);

  localparam int MEM_WORDS = 2 ** IDX_W;
  localparam logic [3:0] MAXP = 4'(MAX_PENDING);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [IDX_W-1:0]  idx;
  logic              acc_rd;
  logic              acc_wr;
  logic              collide;
  logic              pipe_v_q [RD_LATENCY];
  logic [DATA_W-1:0] pipe_d_q [RD_LATENCY];
  logic [2:0]        cnt_q;
  logic [2:0]        cnt_d;
  logic              err_q;

  // Upper address bits alias onto the same storage word.
  assign idx = address_sdram[IDX_W-1:0];
  wire unused_addr_hi = ^address_sdram[ADDR_W-1:IDX_W];

  // Stall everything once the outstanding-read budget is used up.
  assign wait_request = ({1'b0, cnt_q} >= MAXP);

  // A read and a write together is a protocol error and performs neither.
  assign collide = sdram_read_en & sdram_write_en & ~wait_request;
  assign acc_rd  = sdram_read_en & ~sdram_write_en & ~wait_request;
  assign acc_wr  = sdram_write_en & ~sdram_read_en & ~wait_request;

  // Storage is deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (acc_wr) mem_q[idx] <= write_data;
  end

  // Latency pipeline; each data stage only loads alongside a valid, so the
  // tail (read_data) holds its last returned word between strobes.
  for (genvar g = 0; g < RD_LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_head
      // Head stage captures storage at the acceptance edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_v_q[0] <= 1'b0;
          pipe_d_q[0] <= '0;
        end else begin
          pipe_v_q[0] <= acc_rd;
          if (acc_rd) pipe_d_q[0] <= mem_q[idx];
        end
      end
    end else begin : g_body
      // Later stages shift the head forward one cycle at a time.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_v_q[g] <= 1'b0;
          pipe_d_q[g] <= '0;
        end else begin
          pipe_v_q[g] <= pipe_v_q[g-1];
          if (pipe_v_q[g-1]) pipe_d_q[g] <= pipe_d_q[g-1];
        end
      end
    end
  end

  // Outstanding count: +1 per accepted read, -1 per returned read.
  always_comb begin
    cnt_d = cnt_q;
    case ({acc_rd, pipe_v_q[RD_LATENCY-1]})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Count and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (collide) err_q <= 1'b1;
    end
  end

  assign datareadvalid = pipe_v_q[RD_LATENCY-1];
  assign read_data     = pipe_d_q[RD_LATENCY-1];
  assign pending_cnt   = cnt_q;
  assign proto_err     = err_q;

endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - scoreboard bench for sdram_responder
module tb_sdram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sdram_read_en;
  logic        sdram_write_en;
  logic [25:0] address_sdram;
  logic [31:0] write_data;
  logic        wait_request;
  logic [31:0] read_data;
  logic        datareadvalid;
  logic [2:0]  pending_cnt;
  logic        proto_err;

  sdram_responder dut (
    .clk(clk), .rst(rst),
    .sdram_read_en(sdram_read_en), .sdram_write_en(sdram_write_en),
    .address_sdram(address_sdram), .write_data(write_data),
    .wait_request(wait_request), .read_data(read_data),
    .datareadvalid(datareadvalid), .pending_cnt(pending_cnt),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sb_t;

  sb_t         sb[$];
  int          dv_log[$];
  logic [31:0] mem_m [1024];
  int          pend_m;
  bit          err_m;
  logic [31:0] last_m;
  int          cyc;
  int          checks;
  int          failures;
  int          base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    pend_m = 0;
    err_m  = 1'b0;
    last_m = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wait"}, {31'b0, wait_request}, 32'd0);
    chk({tag, "_rdata"}, read_data, 32'd0);
    chk({tag, "_dv"}, {31'b0, datareadvalid}, 32'd0);
    chk({tag, "_pend"}, {29'b0, pending_cnt}, 32'd0);
    chk({tag, "_err"}, {31'b0, proto_err}, 32'd0);
  endtask

  // One bus cycle: drive just after the edge, check at the falling edge,
  // then advance the reference model to the edge that ends the cycle.
  task automatic step(input bit rd, input bit wr, input logic [25:0] a, input logic [31:0] d);
    bit exp_wait;
    bit exp_dv;
    sdram_read_en  = rd;
    sdram_write_en = wr;
    address_sdram  = a;
    write_data     = d;
    @(negedge clk);
    exp_wait = (pend_m >= 2);
    exp_dv   = (sb.size() > 0) && (sb[0].due == cyc);
    if (exp_dv) last_m = sb[0].data;
    chk("wait", {31'b0, wait_request}, {31'b0, exp_wait});
    chk("dv", {31'b0, datareadvalid}, {31'b0, exp_dv});
    chk("rdata", read_data, last_m);
    chk("pend", {29'b0, pending_cnt}, 32'(pend_m));
    chk("err", {31'b0, proto_err}, {31'b0, err_m});
    if (datareadvalid === 1'b1) dv_log.push_back(cyc);
    if (exp_dv) begin
      void'(sb.pop_front());
      pend_m--;
    end
    if (!exp_wait) begin
      if (rd && wr) err_m = 1'b1;
      else begin
        if (wr) mem_m[a[9:0]] = d;
        if (rd) begin
          sb.push_back('{mem_m[a[9:0]], cyc + 3});
          pend_m++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 26'd0, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rst = 1'b1;
    sdram_read_en = 1'b0;
    sdram_write_en = 1'b0;
    address_sdram = '0;
    write_data = '0;
    model_reset();
    #1;
    chk_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T2: write then read next cycle, strobe three cycles after the read
    dv_log.delete();
    base = cyc;
    step(1'b0, 1'b1, 26'd5, 32'h12345678);
    step(1'b1, 1'b0, 26'd5, 32'd0);
    idle(4);
    chk("t2_count", 32'(dv_log.size()), 32'd1);
    if (dv_log.size() > 0) chk("t2_cycle", 32'(dv_log[0]), 32'(base + 4));
    chk("t2_data", read_data, 32'h12345678);

    // T3: backpressure with three reads held until accepted
    step(1'b0, 1'b1, 26'd1, 32'hA0A0A0A1);
    step(1'b0, 1'b1, 26'd2, 32'hB0B0B0B2);
    step(1'b0, 1'b1, 26'd3, 32'hC0C0C0C3);
    dv_log.delete();
    base = cyc;
    step(1'b1, 1'b0, 26'd1, 32'd0);
    step(1'b1, 1'b0, 26'd2, 32'd0);
    step(1'b1, 1'b0, 26'd3, 32'd0);
    step(1'b1, 1'b0, 26'd3, 32'd0);
    step(1'b1, 1'b0, 26'd3, 32'd0);
    idle(4);
    chk("t3_count", 32'(dv_log.size()), 32'd3);
    if (dv_log.size() == 3) begin
      chk("t3_a", 32'(dv_log[0]), 32'(base + 3));
      chk("t3_b", 32'(dv_log[1]), 32'(base + 4));
      chk("t3_c", 32'(dv_log[2]), 32'(base + 7));
    end
    chk("t3_last", read_data, 32'hC0C0C0C3);

    // T4: collision leaves storage alone and sets a sticky flag
    step(1'b0, 1'b1, 26'd7, 32'hAAAA5555);
    dv_log.delete();
    step(1'b1, 1'b1, 26'd7, 32'hFFFF0000);
    idle(5);
    chk("t4_err", {31'b0, proto_err}, 32'd1);
    chk("t4_nodv", 32'(dv_log.size()), 32'd0);
    step(1'b1, 1'b0, 26'd7, 32'd0);
    idle(4);
    chk("t4_data", read_data, 32'hAAAA5555);

    // T5: upper address bits alias onto index 0
    step(1'b0, 1'b1, 26'h400, 32'hCAFEBABE);
    step(1'b1, 1'b0, 26'd0, 32'd0);
    idle(4);
    chk("t5_data", read_data, 32'hCAFEBABE);

    // T1: asynchronous reset with reads in flight
    step(1'b1, 1'b0, 26'd5, 32'd0);
    step(1'b1, 1'b0, 26'd1, 32'd0);
    sdram_read_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_zero("t1");
    #1;
    rst = 1'b0;
    model_reset();
    dv_log.delete();
    idle(6);
    chk("t1_nodv", 32'(dv_log.size()), 32'd0);

    // T6: reset pulsed the cycle after a read is accepted
    step(1'b1, 1'b0, 26'd2, 32'd0);
    dv_log.delete();
    #2;
    rst = 1'b1;
    #1;
    chk_zero("t6");
    #1;
    rst = 1'b0;
    model_reset();
    idle(6);
    chk("t6_nodv", 32'(dv_log.size()), 32'd0);
    chk("t6_pend", {29'b0, pending_cnt}, 32'd0);

    // Storage survives reset
    step(1'b1, 1'b0, 26'd5, 32'd0);
    idle(4);
    chk("keep_data", read_data, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
